// File: rtl/store_pack_pkg.sv
// store_pack_pkg: shared store-path definitions.
//   - store op codes (SW/SH/SB/RSV) as carried on req_op
//   - byte-enable constants for full-word and half-word stores
//   - st_entry_t: one packed write (word address, lane data, byte enables)
//   - byte_lane_be(): one-hot byte enable for a byte offset
package store_pack_pkg;

   localparam logic [1:0] SW  = 2'b00;
   localparam logic [1:0] SH  = 2'b01;
   localparam logic [1:0] SB  = 2'b10;
   localparam logic [1:0] RSV = 2'b11;

   localparam logic [3:0] BE_W   = 4'b1111;
   localparam logic [3:0] BE_HLO = 4'b0011;
   localparam logic [3:0] BE_HHI = 4'b1100;
   localparam logic [3:0] BE_B0  = 4'b0001;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } st_entry_t;

   localparam st_entry_t ENTRY_ZERO = '{addr: 32'h0000_0000, wdata: 32'h0000_0000, be: 4'b0000};

   // Byte lane enable: bit 'lane' set, all others clear.
   function automatic logic [3:0] byte_lane_be(input logic [1:0] lane);
      return BE_B0 << lane;
   endfunction

endpackage

// File: rtl/store_pack_if.sv
// store_pack_if: store request bus plus buffered memory write bus.
//   req_valid/req_ready  request handshake, req_op/req_addr/req_data payload
//   mem_valid/mem_ready  write handshake, mem_addr/mem_wdata/mem_be payload
// master = requester / memory side, slave = store_pack.
interface store_pack_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   modport master (
      output req_valid, req_op, req_addr, req_data, mem_ready,
      input  req_ready, mem_valid, mem_addr, mem_wdata, mem_be
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_data, mem_ready,
      output req_ready, mem_valid, mem_addr, mem_wdata, mem_be
   );
endinterface

// File: rtl/store_pack_st_align.sv
// st_align: combinational store packer and alignment checker.
//   op      store width (SW/SH/SB/RSV)
//   addr    byte address
//   data    rt register value
//   wdata   lane-replicated write data
//   be      byte enables, bit i covers wdata[8i+7:8i]
//   waddr   word-aligned address
//   illegal misaligned sw/sh or reserved op
module st_align
   import store_pack_pkg::*;
(
   input  logic [1:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] waddr,
   output logic        illegal
);

   assign waddr = {addr[31:2], 2'b00};

   // Lane replication, byte enables and legality for each store width.
   always_comb begin
      wdata   = data;
      be      = BE_W;
      illegal = 1'b0;
      case (op)
         SW: begin
            wdata   = data;
            be      = BE_W;
            illegal = (addr[1:0] != 2'b00);
         end
         SH: begin
            wdata = {data[15:0], data[15:0]};
            if (addr[1]) begin
               be = BE_HHI;
            end else begin
               be = BE_HLO;
            end
            illegal = addr[0];
         end
         SB: begin
            wdata   = {4{data[7:0]}};
            be      = byte_lane_be(addr[1:0]);
            illegal = 1'b0;
         end
         default: begin
            wdata   = data;
            be      = 4'b0000;
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/store_pack.sv
// store_pack: store packer with a 2-entry write buffer.
//   clk, reset  sole clock, synchronous active-high reset
//   bus         store_pack_if.slave: request in, memory write out
//   exc_ades    one-cycle pulse after an illegal request is accepted
//   err_addr    address of the last illegal request
//   count       buffered entries, 0..2
// Illegal requests complete the handshake but are never buffered.
module store_pack
   import store_pack_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   store_pack_if.slave bus,
   output logic        exc_ades,
   output logic [31:0] err_addr,
   output logic [1:0]  count
);

   st_entry_t   entry_r [2];
   logic        wr_ptr_r;
   logic        rd_ptr_r;
   logic [1:0]  count_r;
   logic        exc_ades_r;
   logic [31:0] err_addr_r;

   logic [31:0] wdata_s;
   logic [3:0]  be_s;
   logic [31:0] waddr_s;
   logic        illegal_s;
   logic        accept_s;
   logic        push_s;
   logic        pop_s;

   st_align u_st_align (
      .op      (bus.req_op),
      .addr    (bus.req_addr),
      .data    (bus.req_data),
      .wdata   (wdata_s),
      .be      (be_s),
      .waddr   (waddr_s),
      .illegal (illegal_s)
   );

   // Ready depends on buffer occupancy only, never on mem_ready.
   assign bus.req_ready = (count_r != 2'd2);
   assign accept_s      = bus.req_valid && bus.req_ready && !reset;
   assign push_s        = accept_s && !illegal_s;
   assign pop_s         = (count_r != 2'd0) && bus.mem_ready;

   assign bus.mem_valid = (count_r != 2'd0);
   assign bus.mem_addr  = entry_r[rd_ptr_r].addr;
   assign bus.mem_wdata = entry_r[rd_ptr_r].wdata;
   assign bus.mem_be    = entry_r[rd_ptr_r].be;

   assign exc_ades = exc_ades_r;
   assign err_addr = err_addr_r;
   assign count    = count_r;

   // Entry storage: only the slot under the write pointer changes on a push.
   always_ff @(posedge clk) begin
      if (reset) begin
         entry_r[0] <= ENTRY_ZERO;
         entry_r[1] <= ENTRY_ZERO;
      end else if (push_s) begin
         entry_r[wr_ptr_r] <= '{addr: waddr_s, wdata: wdata_s, be: be_s};
      end else begin
         entry_r[0] <= entry_r[0];
         entry_r[1] <= entry_r[1];
      end
   end

   // Pointers and occupancy; push+pop together leaves count unchanged.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Address-error pulse and captured faulting address.
   always_ff @(posedge clk) begin
      if (reset) begin
         exc_ades_r <= 1'b0;
         err_addr_r <= 32'h0000_0000;
      end else begin
         exc_ades_r <= accept_s && illegal_s;
         if (accept_s && illegal_s) begin
            err_addr_r <= bus.req_addr;
         end
      end
   end

endmodule
